// File: rtl/bonsai_merge_pkg.sv
// Shared definitions for the bonsai merge tree output side.
// Holds the default record geometry, the record-pair type and the
// output-buffer entry type ({pair, last}).
package bonsai_merge_pkg;

  localparam int DATA_WIDTH_DEF   = 128;
  localparam int KEY_WIDTH_DEF    = 80;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int STALL_MARGIN_DEF = 3;

  // Two records side by side, as produced by the 2-merger network.
  typedef logic [2*DATA_WIDTH_DEF-1:0] pair_t;

  // One buffered beat: the record pair plus its end-of-run marker.
  typedef struct packed {
    pair_t pair;
    logic  last;
  } fifo_entry_t;

  // True when v is a power of two (v > 0).
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/merger_out_fifo.sv
// First-word-fall-through buffer for the merger output stage.
// Head entry is visible on o_data whenever o_empty=0; a pop is only
// honoured when the buffer holds data, and a push into a full buffer is
// only honoured together with a pop.
module merger_out_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  // Accepted transfers: pop needs data, push needs space or a same-cycle pop.
  assign rd_en = i_pop & ~o_empty;
  assign wr_en = i_push & (~o_full | rd_en);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/merger_output_stage.sv
// Output stage of a 2-merger bitonic network.
// Buffers the lower record pair of each valid beat, feeds the upper pair
// back to the network as the next comparison tuple, raises a registered
// stall with STALL_MARGIN entries of headroom, and flags dropped beats.
// Optional: define MERGER_OUT_STATS_EN to add popped-beat / popped-run counters.
module merger_output_stage
  import bonsai_merge_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int KEY_WIDTH    = KEY_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STALL_MARGIN = STALL_MARGIN_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [2*DATA_WIDTH-1:0] i_elems_0,
  input  logic [2*DATA_WIDTH-1:0] i_elems_1,
  input  logic                    i_stall,
  input  logic                    i_switch_output,
  output logic [2*DATA_WIDTH-1:0] o_top_tuple,
  output logic                    o_stall,
  output logic [2*DATA_WIDTH-1:0] o_data,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready,
`ifdef MERGER_OUT_STATS_EN
  output logic [31:0]             o_beat_count,
  output logic [31:0]             o_run_count,
`endif
  output logic                    o_overflow
);

  localparam int EW = 2*DATA_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_THRESH = CW'(FIFO_DEPTH - STALL_MARGIN);

  // Elaboration guards on the geometry.
  if (KEY_WIDTH > DATA_WIDTH) begin : g_bad_key
    $error("KEY_WIDTH must not exceed DATA_WIDTH");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 8) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 8");
  end

  logic          beat;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [EW-1:0] fifo_head;

  // Beat and transfer qualification.
  assign beat    = ~i_stall;
  assign pop_ok  = i_ready & ~fifo_empty;
  assign push_ok = beat & (~fifo_full | pop_ok);
  assign drop    = beat & fifo_full & ~pop_ok;

  merger_out_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (beat),
    .i_pop   (i_ready),
    .i_data  ({i_elems_0, i_switch_output}),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid = ~fifo_empty;
  assign o_data  = fifo_head[EW-1:1];
  // Masked so a stale storage bit never shows as an end-of-run marker.
  assign o_last  = fifo_head[0] & ~fifo_empty;

  // Occupancy after this edge, used for the early stall decision.
  assign count_next = fifo_count + CW'(push_ok) - CW'(pop_ok);

  // Feedback tuple: upper pair on a continuing beat, zero at a run boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_top_tuple <= '0;
    end else if (push_ok) begin
      o_top_tuple <= i_switch_output ? '0 : i_elems_1;
    end
  end

  // Registered backpressure with headroom for beats already in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_stall <= 1'b0;
    else          o_stall <= (count_next >= STALL_THRESH);
  end

  // Sticky record that a valid beat was lost for lack of space.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

`ifdef MERGER_OUT_STATS_EN
  // Popped-entry and popped-run counters, free-running with wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_beat_count <= '0;
      o_run_count  <= '0;
    end else if (pop_ok) begin
      o_beat_count <= o_beat_count + 32'd1;
      if (o_last) o_run_count <= o_run_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_merger_output_stage.sv
// Self-checking bench for merger_output_stage (default parameters).
module tb_merger_output_stage;

  localparam int DW    = 128;
  localparam int PW    = 2*DW;
  localparam int W     = PW + 1;
  localparam int DEPTH = 16;
  localparam int THR   = 13;

  logic          i_clk;
  logic          i_rst_n;
  logic [PW-1:0] i_elems_0;
  logic [PW-1:0] i_elems_1;
  logic          i_stall;
  logic          i_switch_output;
  logic [PW-1:0] o_top_tuple;
  logic          o_stall;
  logic [PW-1:0] o_data;
  logic          o_last;
  logic          o_valid;
  logic          i_ready;
  logic          o_overflow;
`ifdef MERGER_OUT_STATS_EN
  logic [31:0]   o_beat_count;
  logic [31:0]   o_run_count;
`endif

  merger_output_stage dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_elems_0       (i_elems_0),
    .i_elems_1       (i_elems_1),
    .i_stall         (i_stall),
    .i_switch_output (i_switch_output),
    .o_top_tuple     (o_top_tuple),
    .o_stall         (o_stall),
    .o_data          (o_data),
    .o_last          (o_last),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
`ifdef MERGER_OUT_STATS_EN
    .o_beat_count    (o_beat_count),
    .o_run_count     (o_run_count),
`endif
    .o_overflow      (o_overflow)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Scoreboard and reference state
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] m_top;
  logic          m_stall;
  logic          m_ovf;
  int unsigned   m_beats;
  int unsigned   m_runs;
  int            n_checks;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_top   = '0;
    m_stall = 1'b0;
    m_ovf   = 1'b0;
    m_beats = 0;
    m_runs  = 0;
  endtask

  function automatic logic [PW-1:0] rand_pair();
    logic [PW-1:0] v;
    for (int k = 0; k < PW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_idle();
    i_stall         = 1'b1;
    i_switch_output = 1'b0;
    i_elems_0       = '0;
    i_elems_1       = '0;
  endtask

  task automatic set_beat(input logic [PW-1:0] e0, input logic [PW-1:0] e1, input logic sw);
    i_stall         = 1'b0;
    i_switch_output = sw;
    i_elems_0       = e0;
    i_elems_1       = e1;
  endtask

  // One clock: compare outputs mid-cycle, advance the reference model
  // with the inputs currently applied, then cross the rising edge.
  task automatic cycle();
    logic pop;
    logic full;
    logic push;
    @(negedge i_clk);
    check_eq("valid", W'(o_valid), W'(exp_q.size() != 0));
    check_eq("stall", W'(o_stall), W'(m_stall));
    check_eq("overflow", W'(o_overflow), W'(m_ovf));
    check_eq("top_tuple", W'(o_top_tuple), W'(m_top));
`ifdef MERGER_OUT_STATS_EN
    check_eq("beat_count", W'(o_beat_count), W'(m_beats));
    check_eq("run_count", W'(o_run_count), W'(m_runs));
`endif
    pop  = (exp_q.size() != 0) && i_ready;
    full = (exp_q.size() == DEPTH);
    push = !i_stall && (!full || pop);
    if (pop) begin
      check_eq("data", W'(o_data), W'(exp_q[0][W-1:1]));
      check_eq("last", W'(o_last), W'(exp_q[0][0]));
      m_beats++;
      if (exp_q[0][0]) m_runs++;
      void'(exp_q.pop_front());
    end
    if (!i_stall && full && !pop) m_ovf = 1'b1;
    if (push) begin
      exp_q.push_back({i_elems_0, i_switch_output});
      m_top = i_switch_output ? '0 : i_elems_1;
    end
    m_stall = (exp_q.size() >= THR);
    @(posedge i_clk);
    #1;
  endtask

  // Asynchronous reset pulse applied between edges; outputs checked while held.
  task automatic pulse_reset();
    #1;
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_valid", W'(o_valid), W'(0));
    check_eq("rst_last", W'(o_last), W'(0));
    check_eq("rst_stall", W'(o_stall), W'(0));
    check_eq("rst_overflow", W'(o_overflow), W'(0));
    check_eq("rst_top", W'(o_top_tuple), W'(0));
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    set_idle();
    i_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    i_ready  = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("init_valid", W'(o_valid), W'(0));
    check_eq("init_top", W'(o_top_tuple), W'(0));
    check_eq("init_overflow", W'(o_overflow), W'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Three continuing beats streamed straight through.
    i_ready = 1'b1;
    set_beat(PW'(1), PW'(10), 1'b0); cycle();
    set_beat(PW'(2), PW'(20), 1'b0); cycle();
    set_beat(PW'(3), PW'(30), 1'b0); cycle();
    set_idle();
    cycle();
    check_eq("top_after_run", W'(o_top_tuple), W'(30));
    cycle();

    // Run boundary: entry carries last, feedback tuple clears.
    set_beat(PW'(7), PW'(99), 1'b1); cycle();
    set_idle();
    check_eq("top_cleared", W'(o_top_tuple), W'(0));
    check_eq("last_head", W'(o_last), W'(1));
    cycle();
    cycle();

    // Fill with no drain: stall threshold, full, then a dropped beat.
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      set_beat(PW'(100 + k), PW'(200 + k), 1'b0);
      cycle();
    end
    set_idle();
    cycle();
    check_eq("overflow_set", W'(o_overflow), W'(1));
    drain();

    // Full buffer with simultaneous push and pop keeps order and occupancy.
    pulse_reset();
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      set_beat(rand_pair(), rand_pair(), k[0]);
      cycle();
    end
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_beat(rand_pair(), rand_pair(), 1'b0);
      cycle();
    end
    i_ready = 1'b0;
    set_idle();
    cycle();
    check_eq("full_no_ovf", W'(o_overflow), W'(0));
    check_eq("full_stall", W'(o_stall), W'(1));
    drain();

    // Reset with five entries buffered, then a fresh beat.
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_beat(rand_pair(), rand_pair(), 1'b0);
      cycle();
    end
    set_idle();
    pulse_reset();
    i_ready = 1'b1;
    set_beat(PW'(55), PW'(66), 1'b1); cycle();
    set_idle();
    check_eq("post_rst_valid", W'(o_valid), W'(1));
    check_eq("post_rst_data", W'(o_data), W'(55));
    cycle();
    cycle();

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) set_beat(rand_pair(), rand_pair(), ($urandom_range(0, 4) == 0));
      else set_idle();
      i_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();
    check_eq("final_empty", W'(o_valid), W'(0));
    check_eq("queue_empty", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/merger_output_stage.md
MERGER_OUTPUT_STAGE -- requirements
Module: merger_output_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of one record.
REQ-002 SHALL have parameter KEY_WIDTH, default 80, sort key held in the low KEY_WIDTH bits of each record.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries, power of two, minimum 8.
REQ-004 SHALL have parameter STALL_MARGIN, default 3, free-entry reserve covering the upstream network pipeline.
REQ-005 SHALL have i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have i_elems_0  input  2*DATA_WIDTH  lower record pair from the 2-merger bitonic network.
REQ-008 SHALL have i_elems_1  input  2*DATA_WIDTH  upper record pair from the network.
REQ-009 SHALL have i_stall  input  1  network's delayed stall; a beat is valid when i_stall=0.
REQ-010 SHALL have i_switch_output  input  1  marks the valid beat as the last of a sorted run.
REQ-011 SHALL have o_top_tuple  output  2*DATA_WIDTH  registered feedback pair for the network's next comparison.
REQ-012 SHALL have o_stall  output  1  backpressure to the network input.
REQ-013 SHALL have o_data  output  2*DATA_WIDTH, o_last  output  1, o_valid  output  1  FIFO head.
REQ-014 SHALL have i_ready  input  1  downstream accepts the head when o_valid&i_ready.
REQ-015 SHALL have o_overflow  output  1  sticky; a valid beat arrived with no space.

Function
REQ-016 On a valid beat, SHALL push {i_elems_0, i_switch_output} into the FIFO.
REQ-017 On a valid beat with i_switch_output=0, SHALL load o_top_tuple with i_elems_1 the next cycle.
REQ-018 On a valid beat with i_switch_output=1, SHALL clear o_top_tuple to zero, starting a new run.
REQ-019 On an invalid beat (i_stall=1), SHALL hold o_top_tuple and push nothing.
REQ-020 SHALL implement the FIFO first-word-fall-through: data pushed into an empty FIFO appears on o_data with o_valid=1 one cycle later.
REQ-021 SHALL pop exactly when o_valid&i_ready; o_data/o_last SHALL be stable while o_valid=1 and i_ready=0.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, including when full.
REQ-024 Push with FIFO full and no pop SHALL drop the beat, leave FIFO and o_top_tuple unchanged, and set o_overflow until reset.
REQ-025 o_stall SHALL be registered: o_stall <= (next occupancy >= FIFO_DEPTH-STALL_MARGIN).
REQ-026 Pop from an empty FIFO SHALL be impossible (o_valid=0) and have no effect.

Reset
REQ-027 While i_rst_n=0: occupancy 0, pointers 0, o_valid=0, o_last=0, o_stall=0, o_overflow=0, o_top_tuple=0; o_data don't-care.
REQ-028 Reset mid-operation SHALL discard all buffered entries; first valid beat after release behaves as into an empty FIFO.

Configuration
REQ-029 With MERGER_OUT_STATS_EN defined, SHALL add outputs o_beat_count (32 b, popped entries) and o_run_count (32 b, popped entries with o_last=1), both reset to 0, wrapping at 2^32.
REQ-030 Without MERGER_OUT_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 DATA_WIDTH/KEY_WIDTH defaults, pair typedef and the FIFO entry typedef ({pair,last}) SHALL live in shared package bonsai_merge_pkg.
REQ-032 The buffer SHALL be sub-module merger_out_fifo (push/pop/full/empty/count); tuple feedback, stall and stats logic stay in the top.

Verification
REQ-033 After reset, three valid beats i_elems_0=1,2,3, i_elems_1=10,20,30, i_ready=1 -> o_data 1,2,3 on consecutive cycles one cycle after each push; o_top_tuple ends 30.
REQ-034 Valid beat with i_switch_output=1, i_elems_0=7 -> FIFO entry 7 with o_last=1; o_top_tuple=0 next cycle.
REQ-035 FIFO_DEPTH=16, i_ready=0, 13 valid beats -> o_stall rises the cycle after the 13th push; 16 pushes fill; 17th -> dropped, o_overflow=1.
REQ-036 Full FIFO, simultaneous push and pop -> occupancy stays 16, o_overflow stays 0, order preserved.
REQ-037 i_rst_n pulsed low with 5 entries buffered -> o_valid=0 immediately; all outputs at reset values; next beat passes normally.
REQ-038 MERGER_OUT_STATS_EN defined, 4 popped entries with 1 last -> o_beat_count=4, o_run_count=1.
